// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared encodings and defaults for the bcrypt key-schedule control path
package bcrypt_pkg;
    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_KEY  = 2'd1;
    localparam logic [1:0] OP_SALT = 2'd2;
    localparam int unsigned DEF_MIN_COST = 4;
    localparam int unsigned DEF_MAX_COST = 31;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_INIT, S_KEY, S_SALT, S_FIN} eks_state_t;
endpackage

// File: rtl/eks_iter_counter.sv
// eks_iter_counter: loop counter with a power-of-two limit and a terminal-count flag
module eks_iter_counter #(
    parameter int W    = 32,
    parameter int SH_W = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [SH_W-1:0] i_shift,
    input  logic            i_inc,
    output logic [W-1:0]    o_cnt,
    output logic            o_last
);
    logic [W-1:0] r_lim;
    // o_last flags that the pending increment reaches the limit
    assign o_last = (o_cnt + W'(1)) == r_lim;
    // load clears the count and captures 1<<shift; increments otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_cnt <= '0;
            r_lim <= '0;
        end else if (i_load) begin
            o_cnt <= '0;
            r_lim <= W'(1) << i_shift;
        end else if (i_inc) begin
            o_cnt <= o_cnt + W'(1);
        end
    end
endmodule

// File: rtl/eks_setup_ctrl.sv
// eks_setup_ctrl: sequences INIT then 2^cost KEY/SALT ExpandKey ops on an external engine
module eks_setup_ctrl
    import bcrypt_pkg::*;
#(
    parameter int unsigned SALT_W   = 128,
    parameter int unsigned KEY_W    = 576,
    parameter int unsigned COST_W   = 8,
    parameter int unsigned MIN_COST = DEF_MIN_COST,
    parameter int unsigned MAX_COST = DEF_MAX_COST
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [SALT_W-1:0]   i_salt,
    input  logic [COST_W-1:0]   i_cost,
    input  logic [KEY_W-1:0]    i_key,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_exp_req,
    output logic [1:0]          o_exp_op,
    output logic [SALT_W-1:0]   o_exp_salt,
    output logic [KEY_W-1:0]    o_exp_key,
    input  logic                i_exp_ack,
    output logic [MAX_COST:0]   o_iter_cnt
);
    eks_state_t        r_state;
    logic [COST_W-1:0] r_cost;
    logic              w_load;
    logic              w_inc;
    logic              w_last;
    logic              w_cost_ok;

    assign w_load    = (r_state == S_IDLE) && i_start;
    assign w_inc     = (r_state == S_SALT) && i_exp_ack;
    assign w_cost_ok = (32'(r_cost) >= MIN_COST) && (32'(r_cost) <= MAX_COST);

    eks_iter_counter #(.W(MAX_COST + 1), .SH_W(COST_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (i_cost),
        .i_inc   (w_inc),
        .o_cnt   (o_iter_cnt),
        .o_last  (w_last)
    );

    // control FSM; every output is registered so exp_op steps the cycle after an ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cost     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_exp_req  <= 1'b0;
            o_exp_op   <= OP_INIT;
            o_exp_salt <= '0;
            o_exp_key  <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state    <= S_CHECK;
                    o_busy     <= 1'b1;
                    o_exp_salt <= i_salt;
                    o_exp_key  <= i_key;
                    r_cost     <= i_cost;
                end
                S_CHECK: if (w_cost_ok) begin
                    r_state   <= S_INIT;
                    o_exp_req <= 1'b1;
                    o_exp_op  <= OP_INIT;
                end else begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_err   <= 1'b1;
                end
                S_INIT: if (i_exp_ack) begin
                    r_state  <= S_KEY;
                    o_exp_op <= OP_KEY;
                end
                S_KEY: if (i_exp_ack) begin
                    r_state  <= S_SALT;
                    o_exp_op <= OP_SALT;
                end
                S_SALT: if (i_exp_ack) begin
                    if (w_last) begin
                        r_state   <= S_FIN;
                        o_exp_req <= 1'b0;
                        o_exp_op  <= OP_INIT;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        r_state  <= S_KEY;
                        o_exp_op <= OP_KEY;
                    end
                end
                S_FIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/eks_setup_ctrl.md
Name: eks_setup_ctrl

Overview:
- Parametrised sequencer for the bcrypt expensive key schedule (EksBlowfishSetup).
- Latches salt, cost and key on a start handshake, range-checks cost, then drives an external ExpandKey engine through a req/ack interface.
- Issues one ExpandKey(salt,key), then 2^cost iterations of ExpandKey(0,key) followed by ExpandKey(0,salt).
- Sits between the bcrypt top-level control and the Blowfish state/S-box engine; reports busy/done/err and live progress.

Parameters:
- SALT_W, 128, salt width in bits.
- KEY_W, 576, key width in bits (18 x 32-bit words).
- COST_W, 8, width of the cost input.
- MIN_COST, 4, smallest legal cost.
- MAX_COST, 31, largest legal cost; iteration counter is MAX_COST+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request a new setup; sampled only in IDLE.
- salt  in  SALT_W  salt, captured on accepted start.
- cost  in  COST_W  log2 iteration count, captured on accepted start.
- key  in  KEY_W  key, captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done/err.
- done  out  1  one-cycle pulse: schedule complete.
- err  out  1  one-cycle pulse: cost out of range, no engine ops issued.
- exp_req  out  1  ExpandKey request, held until acked.
- exp_op  out  2  0 = INIT(salt,key), 1 = KEY(0,key), 2 = SALT(0,salt); 3 never driven.
- exp_salt  out  SALT_W  latched salt.
- exp_key  out  KEY_W  latched key.
- exp_ack  in  1  engine completion; an op finishes on a cycle where exp_req and exp_ack are both 1.
- iter_cnt  out  MAX_COST+1  completed KEY+SALT iteration pairs.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; busy, done, err, exp_req, exp_op, iter_cnt all 0; exp_salt and exp_key cleared to 0. Reset takes effect mid-operation with no trailing ack processing.
- FSM states: IDLE, CHECK, INIT, KEY, SALT, FIN.
- IDLE:
  - start=1 latches salt, key and cost; next state CHECK; busy=1 next cycle.
  - start=0 holds IDLE.
- CHECK (1 cycle):
  - cost < MIN_COST or cost > MAX_COST: err pulses next cycle, busy drops in the same cycle, return to IDLE.
  - Otherwise go to INIT.
  - Compare on the full COST_W width; no truncation.
- INIT: exp_req=1, exp_op=0. On ack go to KEY.
- KEY: exp_req=1, exp_op=1. On ack go to SALT.
- SALT: exp_req=1, exp_op=2. On ack, iter_cnt += 1.
  - If the incremented count equals 2^cost, go to FIN.
  - Otherwise go to KEY.
  - 2^cost is computed as 1 shifted left by the latched cost, width MAX_COST+1.
- Back-to-back ops: exp_req stays high across consecutive ops and exp_op changes the cycle after the ack. An engine acking every cycle completes one op per cycle.
- FIN: busy=0, done=1 for exactly one cycle; go to IDLE. iter_cnt holds its final value until the next accepted start, which clears it.
- start while not in IDLE is ignored. start in the FIN cycle is also ignored and must be re-asserted.
- exp_ack with exp_req=0 is ignored.
- exp_salt and exp_key are stable for the whole run.
- Total ops = 1 + 2*2^cost.
- Latency: with ack tied high, start cycle T gives the first exp_req at T+2 and done at T+2+ops.

Decomposition:
- Shared package (bcrypt_pkg): exp_op encodings (OP_INIT=0, OP_KEY=1, OP_SALT=2), FSM state encodings, default MIN_COST/MAX_COST.
- Natural sub-module: eks_iter_counter. It holds the loadable limit (1<<cost), the increment and the terminal-count flag, and is reused by the bcrypt encrypt-64 loop.

Test Plan:
- cost=4, exp_ack tied 1: exactly 33 ops in order INIT, then (KEY,SALT)x16; done at start+35; iter_cnt=16; err never asserted.
- cost=3 and cost=32 (MAX_COST=31): err pulses one cycle at start+2; exp_req never asserts; busy high exactly 1 cycle.
- cost=5, exp_ack random 0-3 cycle delay: 65 ops; exp_op changes only after an ack; exp_salt=128'd32 and exp_key=576'd13 stable throughout.
- start pulsed mid-run at cost=4: ignored; op count still 33; a new start one cycle after done restarts with iter_cnt cleared.
- rst=0 during KEY at iter_cnt=7: next cycle IDLE, exp_req=0, iter_cnt=0; subsequent start runs normally.
- Parameter variant MAX_COST=6, cost=6: 129 ops; iter_cnt reaches 64 without overflow.
